// File: rtl/ycc_coef_ctrl.sv
// ycc_coef_ctrl: double-buffered RGB->YCbCr coefficient bank for the colour-space matrix multiplier.
// A staged (shadow) set is applied to the active set only between frames, never mid-frame.
module ycc_coef_ctrl #(
    parameter int           frameSize  = 76800,
    parameter logic [161:0] RESET_COEF = {18'sd39164, 18'sd76926, 18'sd14982,
                                          -18'sd22138, -18'sd43398, 18'sd65536,
                                          18'sd65536, -18'sd54906, -18'sd10630}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         iWrEn,
    input  logic [3:0]   iWrAddr,
    input  logic [17:0]  iWrData,
    input  logic         iCommit,
    input  logic         iValid,
    input  logic         iDone,
    input  logic         iErrClr,
    output logic [161:0] oCoef,
    output logic         oPending,
    output logic         oCommitAck,
    output logic         oFrameActive,
    output logic [15:0]  oFrameCnt,
    output logic [1:0]   oErr
);
    // state  | meaning
    // IDLE   | between frames, no pixel of a new frame seen yet
    // ACTIVE | frame in progress, fewer than frameSize pixels accepted
    // DRAIN  | all pixels accepted, waiting for the multiplier's iDone
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

    localparam int            CW   = $clog2(frameSize + 1);
    localparam logic [CW-1:0] LAST = CW'(frameSize);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [161:0]  r_shadow;
    logic [161:0]  r_coef;
    logic          r_pending;
    logic          r_ack;
    logic [15:0]   r_frame_cnt;
    logic [1:0]    r_err;

    logic          w_wr_bad;
    logic          w_wr_ok;
    logic          w_frame_end;
    logic          w_seq_err;
    logic          w_swap;
    logic [CW-1:0] w_cnt_inc;

    assign w_wr_bad    = iWrEn && (r_pending || (iWrAddr > 4'd8));
    assign w_wr_ok     = iWrEn && !w_wr_bad;
    assign w_frame_end = (r_state == DRAIN) && iDone;
    assign w_seq_err   = (r_state == DRAIN) ? (iValid && !iDone) : iDone;
    // r_pending is registered, so a commit can never swap in its own cycle
    assign w_swap      = r_pending && !iValid && ((r_state == IDLE) || w_frame_end);
    assign w_cnt_inc   = r_cnt + ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shadow    <= RESET_COEF;
            r_coef      <= RESET_COEF;
            r_pending   <= 1'b0;
            r_ack       <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_err       <= 2'b00;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (w_wr_ok && (iWrAddr == 4'(i)))
                    r_shadow[161 - 18*i -: 18] <= iWrData;
            end

            if (w_swap)
                r_coef <= r_shadow;
            r_ack <= w_swap;

            if (w_swap)
                r_pending <= 1'b0;
            else if (iCommit)
                r_pending <= 1'b1;

            if (w_frame_end)
                r_frame_cnt <= r_frame_cnt + 16'd1;

            r_err <= (iErrClr ? 2'b00 : r_err) | {w_seq_err, w_wr_bad};

            // with frameSize == 1 the first pixel of a frame is also its last
            unique case (r_state)
                IDLE, ACTIVE: begin
                    if (iValid) begin
                        r_cnt   <= w_cnt_inc;
                        r_state <= (w_cnt_inc == LAST) ? DRAIN : ACTIVE;
                    end
                end
                DRAIN: begin
                    if (iDone) begin
                        if (iValid) begin
                            r_cnt   <= ONE;
                            r_state <= (ONE == LAST) ? DRAIN : ACTIVE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign oCoef        = r_coef;
    assign oPending     = r_pending;
    assign oCommitAck   = r_ack;
    assign oFrameActive = (r_state != IDLE);
    assign oFrameCnt    = r_frame_cnt;
    assign oErr         = r_err;
endmodule

// File: tb/tb_ycc_coef_ctrl.sv
// Bench for ycc_coef_ctrl: directed scenarios plus random traffic against a frame-level model,
// and a second frameSize=1 instance running back-to-back frames to exercise the frame-count wrap.
module tb_ycc_coef_ctrl;
    localparam int FS = 4;
    localparam logic [161:0] RC = {18'sd39164, 18'sd76926, 18'sd14982,
                                   -18'sd22138, -18'sd43398, 18'sd65536,
                                   18'sd65536, -18'sd54906, -18'sd10630};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, iWrEn, iCommit, iValid, iDone, iErrClr;
    logic [3:0]   iWrAddr;
    logic [17:0]  iWrData;
    logic [161:0] oCoef;
    logic         oPending, oCommitAck, oFrameActive;
    logic [15:0]  oFrameCnt;
    logic [1:0]   oErr;

    logic         rst2, v2, d2;
    logic [161:0] c2_coef;
    logic         c2_pend, c2_ack, c2_act;
    logic [15:0]  c2_fc;
    logic [1:0]   c2_err;

    ycc_coef_ctrl #(.frameSize(FS)) dut (
        .clk(clk), .reset(reset), .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iWrData(iWrData),
        .iCommit(iCommit), .iValid(iValid), .iDone(iDone), .iErrClr(iErrClr),
        .oCoef(oCoef), .oPending(oPending), .oCommitAck(oCommitAck),
        .oFrameActive(oFrameActive), .oFrameCnt(oFrameCnt), .oErr(oErr));

    ycc_coef_ctrl #(.frameSize(1)) dut_wrap (
        .clk(clk), .reset(rst2), .iWrEn(1'b0), .iWrAddr(4'd0), .iWrData(18'd0),
        .iCommit(1'b0), .iValid(v2), .iDone(d2), .iErrClr(1'b0),
        .oCoef(c2_coef), .oPending(c2_pend), .oCommitAck(c2_ack),
        .oFrameActive(c2_act), .oFrameCnt(c2_fc), .oErr(c2_err));

    typedef struct {
        logic [161:0] coef;
        logic         pend, ack, act;
        logic [15:0]  fc;
        logic [1:0]   err;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit wrap_done = 0;

    // frame-level reference: pixels seen in the current frame, whether it awaits iDone
    logic [17:0]  m_sh[9];
    logic [17:0]  m_ac[9];
    int           m_pix, m_frames;
    bit           m_drain, m_pend, m_ack;
    logic [1:0]   m_err;
    logic [161:0] rc_v;

    task automatic chk(input string nm, input logic [161:0] act, input logic [161:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        rc_v = RC;
        for (int i = 0; i < 9; i++) begin
            m_sh[i] = rc_v[161 - 18*i -: 18];
            m_ac[i] = rc_v[161 - 18*i -: 18];
        end
        m_pix = 0; m_frames = 0; m_drain = 0; m_pend = 0; m_ack = 0; m_err = 2'b00;
    endtask

    task automatic model_step(input bit wr, input int addr, input logic [17:0] data,
                              input bit cm, input bit v, input bit d, input bit clr);
        bit ev0, ev1, swap;
        ev0  = wr && (m_pend || addr > 8);
        ev1  = m_drain ? (v && !d) : d;
        swap = m_pend && !v && ((m_pix == 0) || (m_drain && d));
        if (wr && !ev0) m_sh[addr] = data;
        if (swap) for (int i = 0; i < 9; i++) m_ac[i] = m_sh[i];
        m_ack = swap;
        if (swap) m_pend = 0;
        else if (cm) m_pend = 1;
        if (m_drain) begin
            if (d) begin
                m_frames = (m_frames + 1) % 65536;
                m_pix    = v ? 1 : 0;
                m_drain  = v && (FS == 1);
            end
        end else if (v) begin
            m_pix++;
            if (m_pix == FS) m_drain = 1;
        end
        m_err = (clr ? 2'b00 : m_err) | {ev1, ev0};
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 9; i++) e.coef[161 - 18*i -: 18] = m_ac[i];
        e.pend = m_pend; e.ack = m_ack; e.act = (m_pix != 0);
        e.fc = m_frames[15:0]; e.err = m_err;
        q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit wr, input int addr, input logic [17:0] data,
                       input bit cm, input bit v, input bit d, input bit clr);
        @(negedge clk);
        reset = rst; iWrEn = wr; iWrAddr = 4'(addr); iWrData = data;
        iCommit = cm; iValid = v; iDone = d; iErrClr = clr;
        if (rst) model_reset();
        else model_step(wr, addr, data, cm, v, d, clr);
        push_exp();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();  cyc(0, 0, 0, 18'd0, 0, 0, 0, 0); endtask
    task automatic pix();   cyc(0, 0, 0, 18'd0, 0, 1, 0, 0); endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("coef",    oCoef,        e.coef);
                chk("pending", oPending,     e.pend);
                chk("ack",     oCommitAck,   e.ack);
                chk("active",  oFrameActive, e.act);
                chk("framecnt", oFrameCnt,   e.fc);
                chk("err",     oErr,         e.err);
            end
        end
    end

    initial begin : wrap_run
        rst2 = 1'b1; v2 = 1'b0; d2 = 1'b0;
        repeat (3) @(negedge clk);
        rst2 = 1'b0; v2 = 1'b1;
        @(negedge clk);
        chk("wrap_first_drain", c2_act, 1'b1);
        d2 = 1'b1;
        repeat (65535) @(negedge clk);
        chk("wrap_cnt_max", c2_fc, 16'd65535);
        @(negedge clk);
        chk("wrap_cnt_zero", c2_fc, 16'd0);
        chk("wrap_err", c2_err, 2'b00);
        chk("wrap_active", c2_act, 1'b1);
        v2 = 1'b0; d2 = 1'b0;
        wrap_done = 1;
    end

    initial begin : stim
        logic [161:0] exp_c;
        reset = 1'b1; iWrEn = 0; iWrAddr = 0; iWrData = 0;
        iCommit = 0; iValid = 0; iDone = 0; iErrClr = 0;
        model_reset();
        repeat (3) cyc(1, 0, 0, 18'd0, 0, 0, 0, 0);
        chk("rst_coef", oCoef, RC);
        idle();

        // write index 4 then commit while idle
        cyc(0, 1, 4, 18'sd100, 0, 0, 0, 0);
        cyc(0, 0, 0, 18'd0, 1, 0, 0, 0);
        chk("commit_pend", oPending, 1'b1);
        chk("no_early_swap", oCoef, RC);
        idle();
        chk("idx4_100", oCoef[89:72], 18'd100);
        chk("ack_pulse", oCommitAck, 1'b1);
        chk("pend_clear", oPending, 1'b0);
        idle();
        chk("ack_once", oCommitAck, 1'b0);
        exp_c = RC;
        exp_c[89:72] = 18'd100;

        // commit mid-frame, applied only at iDone
        cyc(0, 1, 0, 18'h12345, 0, 0, 0, 0);
        pix(); pix();
        cyc(0, 0, 0, 18'd0, 1, 1, 0, 0);
        pix();
        chk("hold_in_drain", oCoef, exp_c);
        idle(); idle();
        chk("hold_pend", oPending, 1'b1);
        cyc(0, 0, 0, 18'd0, 0, 0, 1, 0);
        chk("swap_at_done", oCoef[161:144], 18'h12345);
        chk("ack_after_done", oCommitAck, 1'b1);
        chk("frames_1", oFrameCnt, 16'd1);
        exp_c[161:144] = 18'h12345;

        // iDone with iValid while pending: no swap, next frame starts at count 1
        cyc(0, 1, 1, 18'h00777, 0, 0, 0, 0);
        pix();
        cyc(0, 0, 0, 18'd0, 1, 1, 0, 0);
        pix(); pix();
        cyc(0, 0, 0, 18'd0, 0, 1, 1, 0);
        chk("blocked_pend", oPending, 1'b1);
        chk("blocked_active", oFrameActive, 1'b1);
        chk("blocked_coef", oCoef, exp_c);
        pix(); pix(); pix();
        cyc(0, 0, 0, 18'd0, 0, 0, 1, 0);
        chk("late_swap", oCoef[143:126], 18'h00777);
        chk("late_err", oErr, 2'b00);
        exp_c[143:126] = 18'h00777;

        // illegal address and write while pending
        cyc(0, 1, 12, 18'd5, 0, 0, 0, 0);
        chk("err_addr", oErr, 2'b01);
        cyc(0, 0, 0, 18'd0, 1, 0, 0, 0);
        cyc(0, 1, 2, 18'h3FFFF, 0, 0, 0, 0);
        chk("err_pend_wr", oErr, 2'b01);
        chk("shadow_keep", oCoef, exp_c);
        cyc(0, 0, 0, 18'd0, 0, 0, 0, 1);
        chk("err_clr", oErr, 2'b00);
        cyc(0, 1, 13, 18'd0, 0, 0, 0, 1);
        chk("err_beats_clr", oErr, 2'b01);

        // pixel while draining, then reset mid-frame with a commit pending
        pix(); pix(); pix(); pix();
        pix();
        chk("err_overrun", oErr, 2'b11);
        cyc(0, 0, 0, 18'd0, 0, 0, 1, 0);
        chk("frames_after_stray", oFrameCnt, 16'd4);
        chk("idle_after_stray", oFrameActive, 1'b0);
        cyc(0, 1, 3, 18'h0ABCD, 0, 0, 0, 0);
        pix();
        cyc(0, 0, 0, 18'd0, 1, 1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_coef", oCoef, RC);
        chk("arst_pend", oPending, 1'b0);
        chk("arst_active", oFrameActive, 1'b0);
        chk("arst_frames", oFrameCnt, 16'd0);
        chk("arst_err", oErr, 2'b00);
        repeat (2) cyc(1, 0, 0, 18'd0, 0, 0, 0, 0);
        idle(); idle();

        for (int k = 0; k < 3000; k++) begin
            bit r_wr, r_cm, r_v, r_d, r_clr;
            int r_a;
            r_wr  = ($urandom % 4) == 0;
            r_a   = $urandom_range(0, 10);
            r_cm  = ($urandom % 12) == 0;
            r_v   = m_drain ? (($urandom % 6) == 0) : (($urandom % 2) == 0);
            r_d   = m_drain ? (($urandom % 3) == 0) : (($urandom % 50) == 0);
            r_clr = ($urandom % 20) == 0;
            cyc(0, r_wr, r_a, 18'($urandom), r_cm, r_v, r_d, r_clr);
        end
        idle(); idle();

        for (int k = 0; k < 70000 && !wrap_done; k++) @(negedge clk);
        chk("wrap_timeout", wrap_done, 1'b1);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
